// File: rtl/enoc_route_pkg.sv
// Shared port indices, request encodings and helpers for the ENoC route stage.
package enoc_route_pkg;

  // Output-port indices, order c,n,e,s,w,d,u.
  localparam logic [2:0] PORT_C = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_S = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;
  localparam logic [2:0] PORT_D = 3'd5;
  localparam logic [2:0] PORT_U = 3'd6;

  // Bit 0 (leftmost) is the local/core port.
  typedef logic [0:6] port_req_t;

  localparam port_req_t REQ_C = 7'b1000000;
  localparam port_req_t REQ_N = 7'b0100000;
  localparam port_req_t REQ_E = 7'b0010000;
  localparam port_req_t REQ_S = 7'b0001000;
  localparam port_req_t REQ_W = 7'b0000100;
  localparam port_req_t REQ_D = 7'b0000010;
  localparam port_req_t REQ_U = 7'b0000001;

  // Coordinate width; a 1-node dimension still gets a 1-bit (ignored) field.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic port_req_t port_onehot(input logic [2:0] p);
    port_req_t r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // Returns {productive, positive} for one dimension. Torus picks the
  // shorter way round; an exact half ring goes positive.
  function automatic logic [1:0] dim_dir(input int dest, input int loc,
                                         input int n, input bit torus);
    int   dp;
    logic prod;
    logic pos;
    prod = (n > 1) && (dest != loc);
    if (torus) begin
      dp  = (dest >= loc) ? (dest - loc) : (dest + n - loc);
      pos = (2 * dp) <= n;
    end else begin
      pos = dest > loc;
    end
    return {prod, pos};
  endfunction

endpackage

// File: rtl/enoc_route_select.sv
// Credit-based minimal adaptive output choice with a rotating tie pointer.
// Only built when ADAPTIVE_ROUTING_EN is defined.
module enoc_route_select
  import enoc_route_pkg::*;
#(
  parameter int TORUS    = 0,
  parameter int CREDIT_W = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic [2:0]                   prod,
  input  logic [2:0][2:0]              dim_port,
  input  logic [0:6][CREDIT_W-1:0]     i_credit,
  input  port_req_t                    dor_req,
  output port_req_t                    sel_req
);

  logic [1:0]                ptr;
  logic [2:0][CREDIT_W-1:0]  cred;
  logic [CREDIT_W-1:0]       best;
  logic [2:0]                cand;
  logic                      tie;
  logic                      west_first;
  logic [1:0]                win;

  // Pick the productive direction with most credit; ties rotate from ptr.
  always_comb begin
    cred[0] = prod[0] ? i_credit[dim_port[0]] : '0;
    cred[1] = prod[1] ? i_credit[dim_port[1]] : '0;
    cred[2] = prod[2] ? i_credit[dim_port[2]] : '0;
    best = cred[0];
    if (cred[1] > best) best = cred[1];
    if (cred[2] > best) best = cred[2];
    // A zero best means every candidate is starved: no adaptive choice.
    cand = {cred[2] == best, cred[1] == best, cred[0] == best}
           & prod & {3{best != '0}};
    tie  = (cand[0] & cand[1]) | (cand[0] & cand[2]) | (cand[1] & cand[2]);
    case (ptr)
      2'd1:    win = cand[1] ? 2'd1 : (cand[2] ? 2'd2 : 2'd0);
      2'd2:    win = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
      default: win = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    endcase
    // Mesh uses west-first: any westward hop is taken before adapting.
    west_first = (TORUS == 0) && prod[0] && (dim_port[0] == PORT_W);
    sel_req = dor_req;
    if (west_first)          sel_req = REQ_W;
    else if (cand != 3'b000) sel_req = port_onehot(dim_port[win]);
  end

  // Tie pointer steps X->Y->Z only on loads that actually broke a tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        ptr <= 2'd0;
    else if (load && tie && !west_first) ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  end

endmodule

// File: rtl/enoc_adaptive_route_calc.sv
// Registered route computation for one router input port (3D mesh/torus).
// ADAPTIVE_ROUTING_EN: credit-based adaptive selection; otherwise pure
// dimension-ordered routing with i_credit ignored.
module enoc_adaptive_route_calc
  import enoc_route_pkg::*;
#(
  parameter int X_NODES  = 4,
  parameter int Y_NODES  = 4,
  parameter int Z_NODES  = 1,
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int Z_LOC    = 0,
  parameter int TORUS    = 0,
  parameter int CREDIT_W = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [log2(X_NODES)-1:0]   i_x_dest,
  input  logic [log2(Y_NODES)-1:0]   i_y_dest,
  input  logic [log2(Z_NODES)-1:0]   i_z_dest,
  input  logic                       i_val,
  output logic                       o_en,
  input  logic [0:6][CREDIT_W-1:0]   i_credit,
  output port_req_t                  o_output_req,
  output logic                       o_val,
  input  logic                       i_en
);

  logic [1:0]       dx, dy, dz;
  logic [2:0]       prod;
  logic [2:0][2:0]  dim_port;
  port_req_t        dor_req;
  port_req_t        next_req;
  logic             load;

  // Per-dimension direction and the dimension-ordered request.
  always_comb begin
    dx = dim_dir(int'(i_x_dest), X_LOC, X_NODES, TORUS != 0);
    dy = dim_dir(int'(i_y_dest), Y_LOC, Y_NODES, TORUS != 0);
    dz = dim_dir(int'(i_z_dest), Z_LOC, Z_NODES, TORUS != 0);
    prod = {dz[1], dy[1], dx[1]};
    dim_port[0] = dx[0] ? PORT_E : PORT_W;
    dim_port[1] = dy[0] ? PORT_N : PORT_S;
    dim_port[2] = dz[0] ? PORT_U : PORT_D;
    if (prod[0])      dor_req = port_onehot(dim_port[0]);
    else if (prod[1]) dor_req = port_onehot(dim_port[1]);
    else if (prod[2]) dor_req = port_onehot(dim_port[2]);
    else              dor_req = REQ_C;
  end

  // Accept whenever the slot is empty or being drained this cycle.
  assign o_en = !o_val || i_en;
  assign load = i_val && o_en;

`ifdef ADAPTIVE_ROUTING_EN
  enoc_route_select #(
    .TORUS    (TORUS),
    .CREDIT_W (CREDIT_W)
  ) u_select (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .prod     (prod),
    .dim_port (dim_port),
    .i_credit (i_credit),
    .dor_req  (dor_req),
    .sel_req  (next_req)
  );
`else
  logic unused_credit;
  assign unused_credit = ^i_credit;
  assign next_req      = dor_req;
`endif

  // Output slot: load replaces, consume-without-load empties, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_val        <= 1'b0;
      o_output_req <= '0;
    end else if (load) begin
      o_val        <= 1'b1;
      o_output_req <= next_req;
    end else if (i_en) begin
      o_val        <= 1'b0;
      o_output_req <= '0;
    end
  end

endmodule

// File: tb/tb_enoc_adaptive_route_calc.sv
// Scoreboard bench: a mesh 4x4x1 instance at (1,1,0) and a torus 4x1x1
// instance at X=0. Adaptive vectors run only when ADAPTIVE_ROUTING_EN is set.
module tb_enoc_adaptive_route_calc;
  import enoc_route_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       x_dest = '0;
  logic [1:0]       y_dest = '0;
  logic             z_dest = 1'b0;
  logic             val_m = 1'b0, val_t = 1'b0;
  logic             i_en = 1'b1;
  logic [0:6][2:0]  credit = '0;
  logic             en_m, en_t, ov_m, ov_t;
  port_req_t        req_m, req_t;

  enoc_adaptive_route_calc #(
    .X_NODES(4), .Y_NODES(4), .Z_NODES(1), .X_LOC(1), .Y_LOC(1), .Z_LOC(0),
    .TORUS(0), .CREDIT_W(3)
  ) dut_m (
    .clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest),
    .i_z_dest(z_dest), .i_val(val_m), .o_en(en_m), .i_credit(credit),
    .o_output_req(req_m), .o_val(ov_m), .i_en(i_en)
  );

  enoc_adaptive_route_calc #(
    .X_NODES(4), .Y_NODES(1), .Z_NODES(1), .X_LOC(0), .Y_LOC(0), .Z_LOC(0),
    .TORUS(1), .CREDIT_W(3)
  ) dut_t (
    .clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(1'b0),
    .i_z_dest(1'b0), .i_val(val_t), .o_en(en_t), .i_credit(credit),
    .o_output_req(req_t), .o_val(ov_t), .i_en(i_en)
  );

  typedef struct {
    port_req_t req;
    int        cyc;
    string     name;
  } exp_t;

  exp_t      sb[$];
  int        checks = 0, failures = 0, cyc = 0;
  int        act = 0;
  bit        held = 1'b0;
  logic      mv, me;
  port_req_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: the queue head is what the DUT must be presenting right now.
  always @(negedge clk) begin
    if (reset_n) begin
      mv = act ? ov_t : ov_m;
      me = act ? en_t : en_m;
      mr = act ? req_t : req_m;
      chk("o_val", mv, sb.size() != 0);
      chk("o_en", me, (sb.size() == 0) || i_en);
      if (sb.size() != 0) begin
        if (mv && !held) chk({sb[0].name, "_latency"}, cyc, sb[0].cyc);
        chk(sb[0].name, mr, sb[0].req);
        if (i_en) void'(sb.pop_front());
        held = mv && !i_en;
      end else begin
        chk("idle_req_zero", mr, '0);
        held = 1'b0;
      end
    end
  end

  task automatic send(input int u, input logic [1:0] x, input logic [1:0] y,
                      input string nm, input port_req_t exp);
    int n;
    bit acc;
    x_dest = x;
    y_dest = y;
    if (u != 0) val_t = 1'b1; else val_m = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (u != 0) ? en_t : en_m;
      @(posedge clk);
      #1;
      n++;
    end
    val_m = 1'b0;
    val_t = 1'b0;
    if (acc) sb.push_back('{exp, cyc, nm});
    else begin
      checks++;
      failures++;
      $display("FAIL %s: o_en stayed 0, expected 1", nm);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_val", ov_m, 1'b0);
    chk("rst_req", req_m, '0);
    chk("rst_o_en", en_m, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Mesh dimension order, back to back.
    send(0, 2'd3, 2'd0, "mesh_e", REQ_E);
    send(0, 2'd1, 2'd3, "mesh_n", REQ_N);
    send(0, 2'd1, 2'd1, "mesh_c", REQ_C);
    send(0, 2'd0, 2'd1, "mesh_w", REQ_W);
    send(0, 2'd1, 2'd0, "mesh_s", REQ_S);
    send(0, 2'd0, 2'd0, "mesh_xfirst_w", REQ_W);
    drain();

    // Torus ring of 4 at X=0.
    act = 1;
    send(1, 2'd3, 2'd0, "torus_3_w", REQ_W);
    send(1, 2'd2, 2'd0, "torus_2_tie_e", REQ_E);
    send(1, 2'd1, 2'd0, "torus_1_e", REQ_E);
    send(1, 2'd0, 2'd0, "torus_0_c", REQ_C);
    drain();
    act = 0;

`ifdef ADAPTIVE_ROUTING_EN
    credit = '0;
    credit[PORT_E] = 3'd1; credit[PORT_N] = 3'd5;
    send(0, 2'd3, 2'd3, "ad_more_n", REQ_N);
    credit[PORT_E] = 3'd5; credit[PORT_N] = 3'd0;
    send(0, 2'd3, 2'd3, "ad_more_e", REQ_E);
    credit[PORT_E] = 3'd0; credit[PORT_N] = 3'd0;
    send(0, 2'd3, 2'd3, "ad_zero_dor_e", REQ_E);
    credit[PORT_E] = 3'd4; credit[PORT_N] = 3'd4;
    send(0, 2'd3, 2'd3, "ad_tie1_e", REQ_E);
    send(0, 2'd3, 2'd3, "ad_tie2_n", REQ_N);
    send(0, 2'd3, 2'd3, "ad_tie3_e", REQ_E);
    credit[PORT_W] = 3'd0; credit[PORT_N] = 3'd7;
    send(0, 2'd0, 2'd3, "ad_west_first", REQ_W);
    drain();
`endif

    // Backpressure: held request ignores credit changes and new headers.
    send(0, 2'd3, 2'd1, "bp_hold_e", REQ_E);
    i_en = 1'b0;
    val_m = 1'b1;
    x_dest = 2'd1;
    y_dest = 2'd3;
    for (int k = 0; k < 3; k++) begin
      credit[PORT_E] = 3'($urandom_range(7));
      credit[PORT_N] = 3'($urandom_range(7));
      @(posedge clk);
      #1;
    end
    i_en = 1'b1;
    send(0, 2'd1, 2'd3, "bp_next_n", REQ_N);
    drain();

    // Asynchronous reset while a request is held.
    send(0, 2'd3, 2'd0, "rst_held_e", REQ_E);
    i_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_o_val", ov_m, 1'b0);
    chk("async_rst_req", req_m, '0);
    sb.delete();
    held = 1'b0;
    i_en = 1'b1;
    #3;
    reset_n = 1'b1;
    #1;
    chk("post_rst_o_en", en_m, 1'b1);
    @(posedge clk);
    #1;
`ifdef ADAPTIVE_ROUTING_EN
    credit[PORT_E] = 3'd4; credit[PORT_N] = 3'd4;
    send(0, 2'd3, 2'd3, "post_rst_tie_e", REQ_E);
`else
    send(0, 2'd3, 2'd3, "post_rst_dor_e", REQ_E);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
